// File: rtl/uart_tx_serializer.sv
// Async-frame UART transmit serializer: valid/ready byte input, programmable bit period,
// 5-8 data bits LSB first, optional parity, 1 or 2 stop bits, registered tx/bclk.
module uart_tx_serializer #(
    parameter int unsigned DIV_W        = 16,
    parameter logic        DEFAULT_IDLE = 1'b1
) (
    input  logic             pclk,
    input  logic             areset,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       data_bits,
    input  logic             parity_en,
    input  logic             parity_odd,
    input  logic             stop_bits_2,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx,
    output logic             bclk,
    output logic             busy
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t             state;
    logic [DIV_W-1:0]   cnt;
    logic [DIV_W-1:0]   div_q;
    logic [IDX_W-1:0]   bit_cnt;
    logic [IDX_W-1:0]   last_data_q;
    logic [DATA_W-1:0]  shreg;
    logic               par_en_q;
    logic               par_bit_q;
    logic               stop2_q;

    logic [DIV_W-1:0]   div_clamp_c;
    logic [DIV_W-1:0]   half_c;
    logic [DIV_W-1:0]   last_cnt_c;
    logic [DIV_W-1:0]   near_last_c;
    logic [DATA_W-1:0]  mask_c;
    logic               parity_c;
    logic               last_stop_c;
    logic               accept_c;

    // Divisor clamp and per-frame decode; parity covers only the bits actually sent.
    always_comb begin
        div_clamp_c = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
        half_c      = div_q >> 1;
        last_cnt_c  = div_q - DIV_W'(1);
        near_last_c = div_q - DIV_W'(2);
        mask_c      = DATA_W'(8'hFF >> (2'd3 - data_bits));
        parity_c    = (^(tx_data & mask_c)) ^ parity_odd;
        last_stop_c = (bit_cnt == IDX_W'(stop2_q));
        accept_c    = tx_valid && tx_ready;
    end

    // Frame FSM; every output is registered from the values the next cycle will hold.
    always_ff @(posedge pclk) begin
        if (areset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            div_q       <= DIV_W'(2);
            bit_cnt     <= '0;
            last_data_q <= '0;
            shreg       <= '0;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            stop2_q     <= 1'b0;
            tx          <= DEFAULT_IDLE;
            bclk        <= 1'b0;
            busy        <= 1'b0;
            tx_ready    <= 1'b0;
        end else begin
            if (state == S_IDLE) begin
                cnt      <= '0;
                tx       <= DEFAULT_IDLE;
                bclk     <= 1'b0;
                busy     <= 1'b0;
                tx_ready <= 1'b1;
            end else if (cnt != last_cnt_c) begin
                cnt      <= cnt + DIV_W'(1);
                bclk     <= ((cnt + DIV_W'(1)) < half_c);
                busy     <= 1'b1;
                tx_ready <= (state == S_STOP) && last_stop_c && (cnt == near_last_c);
            end else begin
                // Terminal count: advance to the next bit of the frame.
                cnt      <= '0;
                bclk     <= 1'b1;
                busy     <= 1'b1;
                tx_ready <= 1'b0;
                case (state)
                    S_START: begin
                        state   <= S_DATA;
                        bit_cnt <= '0;
                        tx      <= shreg[0];
                    end
                    S_DATA: begin
                        if (bit_cnt == last_data_q) begin
                            bit_cnt <= '0;
                            if (par_en_q) begin
                                state <= S_PARITY;
                                tx    <= par_bit_q;
                            end else begin
                                state <= S_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + IDX_W'(1);
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end
                    S_PARITY: begin
                        state   <= S_STOP;
                        bit_cnt <= '0;
                        tx      <= 1'b1;
                    end
                    S_STOP: begin
                        if (!last_stop_c) begin
                            bit_cnt <= bit_cnt + IDX_W'(1);
                            tx      <= 1'b1;
                        end else begin
                            state    <= S_IDLE;
                            tx       <= DEFAULT_IDLE;
                            bclk     <= 1'b0;
                            busy     <= 1'b0;
                            tx_ready <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        tx    <= DEFAULT_IDLE;
                        bclk  <= 1'b0;
                        busy  <= 1'b0;
                    end
                endcase
            end

            // tx_ready is only high in IDLE or the final stop cycle, so accept overrides both.
            if (accept_c) begin
                state       <= S_START;
                cnt         <= '0;
                bit_cnt     <= '0;
                div_q       <= div_clamp_c;
                shreg       <= tx_data;
                last_data_q <= IDX_W'({1'b0, data_bits}) + IDX_W'(4);
                par_en_q    <= parity_en;
                par_bit_q   <= parity_c;
                stop2_q     <= stop_bits_2;
                tx          <= 1'b0;
                bclk        <= 1'b1;
                busy        <= 1'b1;
                tx_ready    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed self-checking bench for uart_tx_serializer: frame shapes, parity, stop bits,
// back-to-back transfers, mid-frame reset and divisor clamping.
module tb_uart_tx_serializer;

    logic        pclk;
    logic        areset;
    logic [15:0] baud_div;
    logic [1:0]  data_bits;
    logic        parity_en;
    logic        parity_odd;
    logic        stop_bits_2;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx;
    logic        bclk;
    logic        busy;

    int total;
    int bad;

    // Per-cycle capture of {tx, bclk, busy, tx_ready}.
    logic [3:0] obs [0:127];

    uart_tx_serializer #(
        .DIV_W        (16),
        .DEFAULT_IDLE (1'b1)
    ) dut (
        .pclk        (pclk),
        .areset      (areset),
        .baud_div    (baud_div),
        .data_bits   (data_bits),
        .parity_en   (parity_en),
        .parity_odd  (parity_odd),
        .stop_bits_2 (stop_bits_2),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx          (tx),
        .bclk        (bclk),
        .busy        (busy)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_cfg(input logic [15:0] n, input logic [1:0] db, input logic pe,
                           input logic po, input logic s2);
        baud_div    = n;
        data_bits   = db;
        parity_en   = pe;
        parity_odd  = po;
        stop_bits_2 = s2;
    endtask

    // Presents a byte and steps through the accepting edge; leaves us in frame cycle 1.
    task automatic accept_byte(input logic [7:0] d, output bit ok);
        int waited;
        waited   = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && waited < 300) begin
            tick();
            waited++;
        end
        ok = (tx_ready === 1'b1);
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic capture(input int start, input int n);
        for (int i = 0; i < n; i++) begin
            obs[start + i] = {tx, bclk, busy, tx_ready};
            tick();
        end
    endtask

    // Expected {tx, bclk, busy, tx_ready} for cycle k (0-based) of one frame.
    function automatic logic [3:0] exp_line(input int k, input int n, input logic [7:0] d,
                                            input int nd, input int pe, input int po,
                                            input int ns);
        int   bitnum;
        int   f;
        logic t;
        logic p;
        f      = n * (1 + nd + pe + ns);
        bitnum = k / n;
        p      = po[0];
        for (int i = 0; i < nd; i++) p = p ^ d[i];
        if (bitnum == 0)                      t = 1'b0;
        else if (bitnum <= nd)                t = d[bitnum - 1];
        else if (pe != 0 && bitnum == nd + 1) t = p;
        else                                  t = 1'b1;
        return {t, ((k % n) < (n / 2)), 1'b1, (k == f - 1)};
    endfunction

    task automatic test_reset();
        areset   = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        set_cfg(16'd4, 2'b11, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        total++;
        if ({tx, bclk, busy, tx_ready} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_state got %b want 1000", {tx, bclk, busy, tx_ready});
        end
        areset = 1'b0;
        tick();
        total++;
        if ({tx, bclk, busy, tx_ready} !== 4'b1001) begin
            bad++;
            $display("FAIL idle_ready got %b want 1001", {tx, bclk, busy, tx_ready});
        end
    endtask

    task automatic test_8n1();
        bit ok;
        int highs;
        set_cfg(16'd4, 2'b11, 1'b0, 1'b0, 1'b0);
        accept_byte(8'hA5, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL 8n1_accept timeout got 0 want 1"); end
        capture(0, 40);
        highs = 0;
        for (int k = 0; k < 40; k++) begin
            total++;
            if (obs[k] !== exp_line(k, 4, 8'hA5, 8, 0, 0, 1)) begin
                bad++;
                $display("FAIL 8n1_a5 cycle %0d got %b want %b", k, obs[k],
                         exp_line(k, 4, 8'hA5, 8, 0, 0, 1));
            end
            highs += int'(obs[k][2]);
        end
        // Data bits of 0xA5 LSB first: 1,0,1,0,0,1,0,1 at cycles 4,8,...,32.
        total++;
        if ({obs[4][3], obs[8][3], obs[12][3], obs[16][3], obs[20][3], obs[24][3],
             obs[28][3], obs[32][3]} !== 8'b10100101) begin
            bad++;
            $display("FAIL 8n1_bits got %b want 10100101", {obs[4][3], obs[8][3],
                     obs[12][3], obs[16][3], obs[20][3], obs[24][3], obs[28][3], obs[32][3]});
        end
        total++;
        if (highs !== 20) begin bad++; $display("FAIL 8n1_bclk_high got %0d want 20", highs); end
        total++;
        if ({tx, bclk, busy, tx_ready} !== 4'b1001) begin
            bad++;
            $display("FAIL 8n1_after got %b want 1001", {tx, bclk, busy, tx_ready});
        end
    endtask

    task automatic test_parity();
        bit ok;
        // 0x41 in 7 bits: 1,0,0,0,0,0,1 -> two ones -> even parity 0.
        set_cfg(16'd8, 2'b10, 1'b1, 1'b0, 1'b0);
        accept_byte(8'h41, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL par_even_accept timeout got 0 want 1"); end
        capture(0, 80);
        for (int k = 0; k < 80; k++) begin
            total++;
            if (obs[k] !== exp_line(k, 8, 8'h41, 7, 1, 0, 1)) begin
                bad++;
                $display("FAIL par_even cycle %0d got %b want %b", k, obs[k],
                         exp_line(k, 8, 8'h41, 7, 1, 0, 1));
            end
        end
        total++;
        if (obs[64][3] !== 1'b0) begin bad++; $display("FAIL par_even_bit got %b want 0", obs[64][3]); end

        set_cfg(16'd8, 2'b10, 1'b1, 1'b1, 1'b0);
        accept_byte(8'h41, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL par_odd_accept timeout got 0 want 1"); end
        capture(0, 80);
        for (int k = 0; k < 80; k++) begin
            total++;
            if (obs[k] !== exp_line(k, 8, 8'h41, 7, 1, 1, 1)) begin
                bad++;
                $display("FAIL par_odd cycle %0d got %b want %b", k, obs[k],
                         exp_line(k, 8, 8'h41, 7, 1, 1, 1));
            end
        end
        total++;
        if (obs[64][3] !== 1'b1) begin bad++; $display("FAIL par_odd_bit got %b want 1", obs[64][3]); end

        // 0xE1 in 5 bits is 1,0,0,0,0: even parity 1; the ignored upper bits must not count.
        set_cfg(16'd4, 2'b00, 1'b1, 1'b0, 1'b0);
        accept_byte(8'hE1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL par_mask_accept timeout got 0 want 1"); end
        capture(0, 32);
        total++;
        if (obs[24][3] !== 1'b1) begin bad++; $display("FAIL par_mask_bit got %b want 1", obs[24][3]); end
        total++;
        if (obs[31] !== 4'b1011) begin bad++; $display("FAIL par_mask_end got %b want 1011", obs[31]); end
    endtask

    task automatic test_stop2();
        bit ok;
        set_cfg(16'd4, 2'b00, 1'b0, 1'b0, 1'b1);
        accept_byte(8'hFF, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL stop2_accept timeout got 0 want 1"); end
        capture(0, 32);
        for (int k = 0; k < 32; k++) begin
            total++;
            if (obs[k] !== exp_line(k, 4, 8'hFF, 5, 0, 0, 2)) begin
                bad++;
                $display("FAIL stop2 cycle %0d got %b want %b", k, obs[k],
                         exp_line(k, 4, 8'hFF, 5, 0, 0, 2));
            end
        end
        // Ready must not rise at the end of the first stop bit (cycle 28).
        total++;
        if (obs[27][0] !== 1'b0) begin bad++; $display("FAIL stop2_early_ready got %b want 0", obs[27][0]); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL stop2_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        set_cfg(16'd4, 2'b11, 1'b0, 1'b0, 1'b0);
        accept_byte(8'h00, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL b2b_accept timeout got 0 want 1"); end
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        capture(0, 40);
        tx_valid = 1'b0;
        capture(40, 40);
        for (int k = 0; k < 80; k++) begin
            total++;
            if (obs[k] !== ((k < 40) ? exp_line(k, 4, 8'h00, 8, 0, 0, 1)
                                     : exp_line(k - 40, 4, 8'hFF, 8, 0, 0, 1))) begin
                bad++;
                $display("FAIL b2b cycle %0d got %b want %b", k, obs[k],
                         (k < 40) ? exp_line(k, 4, 8'h00, 8, 0, 0, 1)
                                  : exp_line(k - 40, 4, 8'hFF, 8, 0, 0, 1));
            end
        end
        total++;
        if (obs[40][3] !== 1'b0) begin bad++; $display("FAIL b2b_second_start got %b want 0", obs[40][3]); end
        total++;
        if ({tx, busy} !== 2'b10) begin bad++; $display("FAIL b2b_after got %b want 10", {tx, busy}); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        set_cfg(16'd4, 2'b11, 1'b0, 1'b0, 1'b0);
        accept_byte(8'h00, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rst_mid_accept timeout got 0 want 1"); end
        capture(0, 12);
        // Now in the first cycle of the 3rd data bit: tx=0, bclk=1.
        total++;
        if ({tx, bclk, busy} !== 3'b011) begin
            bad++;
            $display("FAIL rst_mid_pre got %b want 011", {tx, bclk, busy});
        end
        areset = 1'b1;
        tick();
        total++;
        if ({tx, bclk, busy, tx_ready} !== 4'b1000) begin
            bad++;
            $display("FAIL rst_mid_post got %b want 1000", {tx, bclk, busy, tx_ready});
        end
        areset = 1'b0;
        tick();
        tick();
        total++;
        if ({tx, bclk, busy, tx_ready} !== 4'b1001) begin
            bad++;
            $display("FAIL rst_mid_idle got %b want 1001", {tx, bclk, busy, tx_ready});
        end
        accept_byte(8'h3C, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rst_mid_reaccept timeout got 0 want 1"); end
        capture(0, 40);
        for (int k = 0; k < 40; k++) begin
            total++;
            if (obs[k] !== exp_line(k, 4, 8'h3C, 8, 0, 0, 1)) begin
                bad++;
                $display("FAIL rst_mid_resend cycle %0d got %b want %b", k, obs[k],
                         exp_line(k, 4, 8'h3C, 8, 0, 0, 1));
            end
        end
    endtask

    task automatic test_div_clamp();
        bit ok;
        // baud_div=0 clamps to 2; a mid-frame change to 9 must be ignored.
        set_cfg(16'd0, 2'b11, 1'b0, 1'b0, 1'b0);
        accept_byte(8'h96, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL div0_accept timeout got 0 want 1"); end
        baud_div = 16'd9;
        capture(0, 20);
        for (int k = 0; k < 20; k++) begin
            total++;
            if (obs[k] !== exp_line(k, 2, 8'h96, 8, 0, 0, 1)) begin
                bad++;
                $display("FAIL div0 cycle %0d got %b want %b", k, obs[k],
                         exp_line(k, 2, 8'h96, 8, 0, 0, 1));
            end
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL div0_len got busy %b want 0", busy); end

        set_cfg(16'd1, 2'b11, 1'b0, 1'b0, 1'b0);
        accept_byte(8'h69, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL div1_accept timeout got 0 want 1"); end
        baud_div = 16'd7;
        capture(0, 20);
        for (int k = 0; k < 20; k++) begin
            total++;
            if (obs[k] !== exp_line(k, 2, 8'h69, 8, 0, 0, 1)) begin
                bad++;
                $display("FAIL div1 cycle %0d got %b want %b", k, obs[k],
                         exp_line(k, 2, 8'h69, 8, 0, 0, 1));
            end
        end

        // Divisor latched at accept: N=4 frame while the input reads 16.
        set_cfg(16'd4, 2'b11, 1'b0, 1'b0, 1'b0);
        accept_byte(8'hC3, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL divchg_accept timeout got 0 want 1"); end
        baud_div = 16'd16;
        capture(0, 40);
        for (int k = 0; k < 40; k++) begin
            total++;
            if (obs[k] !== exp_line(k, 4, 8'hC3, 8, 0, 0, 1)) begin
                bad++;
                $display("FAIL divchg cycle %0d got %b want %b", k, obs[k],
                         exp_line(k, 4, 8'hC3, 8, 0, 0, 1));
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_8n1();
        test_parity();
        test_stop2();
        test_back_to_back();
        test_reset_mid_frame();
        test_div_clamp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Transmit-side serializer that drives the tx and bclk pins of the UART interface. It accepts parallel bytes over a valid/ready handshake and generates the bit-period timing from pclk with a programmable divisor. It emits standard asynchronous frames: start bit, 5-8 data bits LSB first, optional parity, 1 or 2 stop bits. It sits between the transmitter driver logic and the uart_if pins.

Parameters:
DIV_W, 16, width of baud divisor input
DEFAULT_IDLE, 1'b1, line level driven on tx when idle or in reset

Ports:
pclk  input  1  system clock; all logic on rising edge
areset  input  1  reset, synchronous, active-high
baud_div  input  DIV_W  bit period in pclk cycles (N); values 0 and 1 treated as 2
data_bits  input  2  00=5, 01=6, 10=7, 11=8 data bits
parity_en  input  1  1 = append parity bit
parity_odd  input  1  1 = odd parity, 0 = even parity
stop_bits_2  input  1  1 = two stop bits, 0 = one
tx_data  input  8  byte to send; bits above data_bits length ignored
tx_valid  input  1  tx_data valid
tx_ready  output  1  serializer can accept a byte this cycle
tx  output  1  serial line
bclk  output  1  bit-rate clock aligned to tx bit periods
busy  output  1  frame in progress

Behaviour:
- Reset (areset=1 at a pclk edge): state=IDLE, tx=DEFAULT_IDLE, bclk=0, busy=0, tx_ready=0; counters cleared. Reset mid-frame abandons the frame; tx returns high the cycle after the reset edge; no partial bits resume.
- tx_ready is registered: 1 in IDLE when not in reset, and 1 during the final pclk cycle of the last stop bit; 0 otherwise.
- Accept on tx_valid && tx_ready at an edge. tx_data, data_bits, parity_en, parity_odd, stop_bits_2 and baud_div (clamped) are latched at accept. Config changes mid-frame have no effect.
- States: IDLE -> START -> DATA -> (PARITY if parity_en) -> STOP -> IDLE.
- Accept in the last stop cycle goes directly to START, giving zero idle gap between frames.
- Latency: tx drives 0 (start bit) in the cycle immediately after the accept edge.
- Every bit lasts exactly N pclk cycles. A bit counter 0..N-1 increments per cycle while busy; terminal count advances the bit.
- DATA: shifts out LSB first, data_bits+5 bits.
- PARITY: even parity = XOR of transmitted data bits only; odd parity = its inverse.
- STOP: tx=1 for N cycles (1 stop bit) or 2N cycles (2 stop bits).
- Frame length = N * (1 + D + P + S) cycles, where D = data bits, P = parity bit (0/1), S = stop bits (1/2).
- bclk: 1 for the first floor(N/2) cycles of each bit period, 0 for the rest. Held 0 in IDLE and during reset.
- busy: 1 from the cycle after accept until the cycle after the last stop cycle completes. Remains 1 across a back-to-back accept.
- tx and bclk are registered outputs with no combinational path from inputs.

Test Plan:
- Reset, then N=4, 8N1, send 0xA5 -> tx 0 on the cycle after accept, then 1,0,1,0,0,1,0,1, then stop 1, each bit 4 cycles. Frame is 40 cycles. tx_ready returns 1 on cycle 40. bclk is high for 2 of every 4 cycles.
- N=8, 7 data bits, even parity, 0x41 -> data 1,0,0,0,0,0,1 then parity 0. Same frame with odd parity -> parity 1. Frame is 80 cycles.
- N=4, 5 data bits, 2 stop bits, tx_data=0xFF -> 5 data 1s only, then stop high for 8 cycles. Total 32 cycles.
- Back-to-back: tx_valid held high with 0x00 then 0xFF at N=4, 8N1 -> second start bit begins on the cycle right after the first frame's last stop cycle. busy stays 1 for 80 cycles.
- Reset asserted in the 3rd data bit -> tx=1, bclk=0, busy=0, tx_ready=0 the next cycle. A new byte accepted after reset is sent cleanly.
- baud_div=0 and baud_div=1 -> bit period is 2 cycles. Changing baud_div mid-frame does not alter the current frame's timing.
